// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and helper functions
// Contents: mode timing for 640x480@60 and 800x600@60, clog2(), colour_expand().
// Imported by vga_scan_engine, vga_delay_line and vga_address_translator.
package vga_pkg;

   // 640x480@60, 25.175 MHz, both syncs active-low
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;

   // 800x600@60, 40 MHz, both syncs active-high
   localparam int VGA800_H_ACTIVE = 800;
   localparam int VGA800_H_FP     = 40;
   localparam int VGA800_H_SYNC   = 128;
   localparam int VGA800_H_BP     = 88;
   localparam int VGA800_V_ACTIVE = 600;
   localparam int VGA800_V_FP     = 1;
   localparam int VGA800_V_SYNC   = 4;
   localparam int VGA800_V_BP     = 23;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

   // Replicates the low bpc bits of chan MSB-first across dac_w bits; the last
   // copy is truncated so full-scale input always maps to full-scale output.
   function automatic logic [31:0] colour_expand(input logic [9:0] chan, input int bpc,
                                                 input int dac_w);
      logic [31:0] result;
      result = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < dac_w) begin
            result[dac_w - 1 - i] = chan[bpc - 1 - (i % bpc)];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// rtl/vga_scan_engine_if.sv - video memory read bus between scan engine and framebuffer
// master (scan engine): drives memory_address, mem_rd_en; receives pixel_colour.
// slave  (video RAM)  : returns pixel_colour a fixed latency after memory_address.
interface vga_scan_engine_if #(
   parameter int ADDR_W = 18,
   parameter int BPC    = 1
);
   logic [ADDR_W-1:0]  memory_address;
   logic               mem_rd_en;
   logic [3*BPC-1:0]   pixel_colour;

   modport master (output memory_address, output mem_rd_en, input pixel_colour);
   modport slave  (input memory_address, input mem_rd_en, output pixel_colour);
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipe with asynchronous reset value
// vga_clock : clock
// resetn    : asynchronous active-low reset, every stage loads RESET_VAL
// sample    : value entering the pipe
// delayed   : sample as it was DEPTH cycles earlier
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             vga_clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] delayed
);
   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= sample;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign delayed = stage[DEPTH-1];
endmodule

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - VGA timing, scaled framebuffer read and double-buffered scan-out
// vga_clock, resetn    : pixel clock, asynchronous active-low reset
// fb_select            : requested buffer, taken only in the frame_start cycle
// mem                  : framebuffer read bus (memory_address, mem_rd_en, pixel_colour)
// VGA_R/G/B            : registered DAC colour
// VGA_HS/VS/BLANK      : syncs and active-video flag, aligned with colour
// VGA_SYNC, VGA_CLK    : constant 1, pixel clock forwarded
// frame_start          : counters at (0,0), undelayed
// in_vblank            : line >= V_ACTIVE, undelayed
// active_buf           : buffer being scanned
module vga_scan_engine
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = VGA640_H_ACTIVE,
   parameter int H_FP        = VGA640_H_FP,
   parameter int H_SYNC      = VGA640_H_SYNC,
   parameter int H_BP        = VGA640_H_BP,
   parameter int V_ACTIVE    = VGA640_V_ACTIVE,
   parameter int V_FP        = VGA640_V_FP,
   parameter int V_SYNC      = VGA640_V_SYNC,
   parameter int V_BP        = VGA640_V_BP,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int SCALE_LOG2  = 1,
   parameter int BPC         = 1,
   parameter int DAC_W       = 10,
   parameter int MEM_LATENCY = 1,
   parameter int DOUBLE_BUF  = 1,
   parameter int ADDR_W      = 18
) (
   input  logic               vga_clock,
   input  logic               resetn,
   input  logic               fb_select,
   vga_scan_engine_if.master  mem,
   output logic [DAC_W-1:0]   VGA_R,
   output logic [DAC_W-1:0]   VGA_G,
   output logic [DAC_W-1:0]   VGA_B,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic               VGA_CLK,
   output logic               frame_start,
   output logic               in_vblank,
   output logic               active_buf
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = (clog2(H_TOTAL) < 1) ? 1 : clog2(H_TOTAL);
   localparam int VW       = (clog2(V_TOTAL) < 1) ? 1 : clog2(V_TOTAL);
   localparam int DOTS     = H_ACTIVE >> SCALE_LOG2;
   localparam int FB_WORDS = DOTS * (V_ACTIVE >> SCALE_LOG2);
   localparam int SMASK    = (1 << SCALE_LOG2) - 1;

   if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
      $error("vga_scan_engine: active area not divisible by 2**SCALE_LOG2");
   end
   if ((1 + DOUBLE_BUF) * FB_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
      $error("vga_scan_engine: ADDR_W too small for the framebuffer");
   end

   logic [HW-1:0]     hcnt;
   logic [VW-1:0]     vcnt;
   logic [ADDR_W-1:0] row_base;
   logic              h_wrap, v_wrap, active_video, hs_level, vs_level;
   logic              buf_next;
   logic [ADDR_W-1:0] buf_base, xdot;
   logic [2:0]        sync_early;
   logic              hs_early, vs_early, blank_early;
   logic [DAC_W-1:0]  r_exp, g_exp, b_exp;

   assign h_wrap       = (hcnt == HW'(H_TOTAL - 1));
   assign v_wrap       = (vcnt == VW'(V_TOTAL - 1));
   assign active_video = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
   assign hs_level     = ((hcnt >= HW'(H_ACTIVE + H_FP)) &&
                          (hcnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1))) ? HS_POL : ~HS_POL;
   assign vs_level     = ((vcnt >= VW'(V_ACTIVE + V_FP)) &&
                          (vcnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1))) ? VS_POL : ~VS_POL;

   // Gated with resetn so the pulse stays low while the counters are held at (0,0).
   assign frame_start = resetn && (hcnt == '0) && (vcnt == '0);
   assign in_vblank   = (vcnt >= VW'(V_ACTIVE));

   // The (0,0) address is issued in the same cycle active_buf is loaded, so the
   // address path looks at the value active_buf is about to take.
   assign buf_next = (DOUBLE_BUF != 0) ? (frame_start ? fb_select : active_buf) : 1'b0;
   assign buf_base = buf_next ? ADDR_W'(FB_WORDS) : '0;
   assign xdot     = ADDR_W'(hcnt >> SCALE_LOG2);

   assign VGA_SYNC = 1'b1;
   assign VGA_CLK  = vga_clock;

   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         hcnt               <= '0;
         vcnt               <= '0;
         row_base           <= '0;
         active_buf         <= 1'b0;
         mem.memory_address <= '0;
         mem.mem_rd_en      <= 1'b0;
      end else begin
         hcnt <= h_wrap ? '0 : hcnt + 1'b1;
         if (h_wrap) begin
            vcnt <= v_wrap ? '0 : vcnt + 1'b1;
         end
         // One framebuffer row serves 2**S screen lines; step on the last of them.
         if (h_wrap && v_wrap) begin
            row_base <= '0;
         end else if (h_wrap && ((vcnt & VW'(SMASK)) == VW'(SMASK)) && (vcnt < VW'(V_ACTIVE))) begin
            row_base <= row_base + ADDR_W'(DOTS);
         end
         active_buf         <= buf_next;
         mem.memory_address <= active_video ? (buf_base + row_base + xdot) : '0;
         mem.mem_rd_en      <= active_video;
      end
   end

   // Syncs/blank travel MEM_LATENCY+1 stages here and one more in the output
   // register below, matching address register + memory + colour register.
   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (MEM_LATENCY + 1),
      .RESET_VAL ({~HS_POL, ~VS_POL, 1'b0})
   ) u_sync_pipe (
      .vga_clock (vga_clock),
      .resetn    (resetn),
      .sample    ({hs_level, vs_level, active_video}),
      .delayed   (sync_early)
   );
   assign {hs_early, vs_early, blank_early} = sync_early;

   always_comb begin
      r_exp = DAC_W'(colour_expand(10'(mem.pixel_colour[3*BPC-1 -: BPC]), BPC, DAC_W));
      g_exp = DAC_W'(colour_expand(10'(mem.pixel_colour[2*BPC-1 -: BPC]), BPC, DAC_W));
      b_exp = DAC_W'(colour_expand(10'(mem.pixel_colour[BPC-1 -: BPC]), BPC, DAC_W));
   end

   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         VGA_HS    <= ~HS_POL;
         VGA_VS    <= ~VS_POL;
         VGA_BLANK <= 1'b0;
      end else begin
         VGA_R     <= blank_early ? r_exp : '0;
         VGA_G     <= blank_early ? g_exp : '0;
         VGA_B     <= blank_early ? b_exp : '0;
         VGA_HS    <= hs_early;
         VGA_VS    <= vs_early;
         VGA_BLANK <= blank_early;
      end
   end
endmodule
